mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_lsu_align.sv | 66 ++++++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage:
// load/store funct3 codes and the stage FSM encoding.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } mem_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: write strobes, store data replication,
// load data extraction/extension and misalignment detection.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SW   = XLEN / 8
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [SW-1:0]   wstrb,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misalign
);

    localparam int OW = $clog2(SW);

    logic [OW-1:0]   off;
    logic [XLEN-1:0] sh;
    logic [7:0]      mask;

    assign off   = addr[OW-1:0];
    assign sh    = rdata >> {off, 3'b000};
    assign wstrb = SW'(mask) << off;

    // Decode access size from funct3[1:0]; funct3[2] selects zero-extension.
    always_comb begin
        mask      = 8'h00;
        misalign  = 1'b0;
        wdata_rep = wdata;
        rdata_ext = sh;
        case (funct3[1:0])
            2'd0: begin
                mask      = 8'h01;
                wdata_rep = {SW{wdata[7:0]}};
                rdata_ext = funct3[2] ? XLEN'(sh[7:0])
                                      : XLEN'($signed(sh[7:0]));
            end
            2'd1: begin
                mask      = 8'h03;
                misalign  = addr[0];
                wdata_rep = {(SW/2){wdata[15:0]}};
                rdata_ext = funct3[2] ? XLEN'(sh[15:0])
                                      : XLEN'($signed(sh[15:0]));
            end
            2'd2: begin
                mask      = 8'h0F;
                misalign  = (|addr[1:0]) | (funct3[2] & (XLEN == 32));
                wdata_rep = {(SW/4){wdata[31:0]}};
                rdata_ext = funct3[2] ? XLEN'(sh[31:0])
                                      : XLEN'($signed(sh[31:0]));
            end
            default: begin
                // dword; funct3 7 has no meaning and is rejected as misaligned
                mask      = 8'hFF;
                misalign  = (|addr[2:0]) | funct3[2] | (XLEN == 32);
                wdata_rep = wdata;
                rdata_ext = sh;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues aligned loads/stores on a req/gnt/rvalid
// bus and hands results downstream over a valid/ready handshake.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SW   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_rd,
    input  logic            in_wb_en,
    input  logic            in_ebreak,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic [XLEN-1:0] out_wb_data,
    output logic            out_ebreak,
    output logic            out_misalign,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    input  logic            out_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [SW-1:0]   mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    mem_state_t state;

    logic [2:0]      f3_q;
    logic            load_q;
    logic            sel_in;
    logic [2:0]      a_f3;
    logic [XLEN-1:0] a_addr;
    logic [SW-1:0]   a_wstrb;
    logic [XLEN-1:0] a_wdata;
    logic [XLEN-1:0] a_rext;
    logic            a_mis;
    logic            ld_st;
    logic            go_mem;
    logic            accept;

    assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign ld_st    = in_load | in_store;
    assign go_mem   = ld_st & ~a_mis;

    // New instruction drives the aligner while accepting; otherwise the
    // captured request so returning load data is extracted correctly.
    assign sel_in = (state == IDLE) | (state == HOLD);
    assign a_f3   = sel_in ? in_funct3 : f3_q;
    assign a_addr = sel_in ? in_addr : mem_addr;

    lsu_align #(.XLEN(XLEN), .SW(SW)) u_align (
        .funct3    (a_f3),
        .addr      (a_addr),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .wstrb     (a_wstrb),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rext),
        .misalign  (a_mis)
    );

    // Stage FSM with all registered outputs and captured fields.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            f3_q         <= 3'd0;
            load_q       <= 1'b0;
            out_rd       <= 5'd0;
            out_wb_en    <= 1'b0;
            out_wb_data  <= '0;
            out_ebreak   <= 1'b0;
            out_misalign <= 1'b0;
            out_pc       <= '0;
            out_instr    <= 32'd0;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (flush) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        mem_addr     <= in_addr;
                        mem_wdata    <= a_wdata;
                        mem_wstrb    <= go_mem ? a_wstrb : '0;
                        mem_we       <= in_store & go_mem;
                        f3_q         <= in_funct3;
                        load_q       <= in_load;
                        out_rd       <= in_rd;
                        out_wb_en    <= in_wb_en & ~in_store
                                        & ~(ld_st & a_mis);
                        out_wb_data  <= in_result;
                        out_ebreak   <= in_ebreak;
                        out_misalign <= ld_st & a_mis;
                        out_pc       <= in_pc;
                        out_instr    <= in_instr;
                        if (go_mem) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (!load_q || mem_rvalid) begin
                            if (load_q) out_wb_data <= a_rext;
                            state     <= flush ? IDLE : HOLD;
                            out_valid <= ~flush;
                        end else begin
                            state <= flush ? DRAIN : WAIT;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        out_wb_data <= a_rext;
                        state       <= flush ? IDLE : HOLD;
                        out_valid   <= ~flush;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_req) begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            if (!load_q || mem_rvalid) state <= IDLE;
                        end
                    end else if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
